pipe_chain: RTL and testbench

- Parametrised successor to the hand-wired per-stage pipeline registers: one instance forms an N-stage chain of WIDTH-bit registers.
- Each stage carries a valid bit and obeys per-stage stall/flush vectors driven by the hazard unit.
- Input side uses a valid/ready handshake; output side is handshaked against the consumer.
- Exposes per-stage taps and valids for forwarding logic, plus an occupancy count.

---
 rtl/pipe_chain.sv | 132 +++++++++++++
 tb/tb_pipe_chain.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_chain.sv
// pipe_chain: parametrised N-stage register chain with per-stage valid, stall and flush.
// The input is a valid/ready handshake into stage 0, the output a valid/ready handshake
// out of stage STAGES-1. Per-stage taps, valids and a registered occupancy count are
// exported for forwarding logic.
//
// Build option: define PIPE_CHAIN_BUBBLE_COLLAPSE_EN to let empty stages load while
// downstream is blocked (bubble squeezing). Left undefined, the chain moves as a whole
// and bubbles are preserved.
module pipe_chain #(
    parameter int unsigned STAGES = 4,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned CNTW   = $clog2(STAGES + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,        // asynchronous, active-low
    input  logic                      in_valid_i,
    input  logic [WIDTH-1:0]          in_data_i,
    output logic                      in_ready_o,
    input  logic [STAGES-1:0]         stall_i,
    input  logic [STAGES-1:0]         flush_i,
    output logic                      out_valid_o,
    output logic [WIDTH-1:0]          out_data_o,
    input  logic                      out_ready_i,
    output logic [STAGES*WIDTH-1:0]   tap_data_o,
    output logic [STAGES-1:0]         tap_valid_o,
    output logic [CNTW-1:0]           occupancy_o
);

    // hold[STAGES] is the consumer side; hold[k] == 1 keeps stage k in place.
    logic [STAGES:0]       hold;

    logic [STAGES-1:0]     valid_q, valid_d;
    logic [WIDTH-1:0]      data_q [STAGES];
    logic [WIDTH-1:0]      data_d [STAGES];
    logic [CNTW-1:0]       occ_q, occ_d;

    // Source of each stage: stage 0 takes the producer, stage k takes stage k-1.
    logic [STAGES-1:0]     src_valid;
    logic [WIDTH-1:0]      src_data [STAGES];

    // Hold chain, evaluated from the consumer back towards the producer.
    always_comb begin
        hold         = '0;
        hold[STAGES] = !out_ready_i;
        for (int k = STAGES - 1; k >= 0; k--) begin
`ifdef PIPE_CHAIN_BUBBLE_COLLAPSE_EN
            // An empty stage may always load unless it is itself stalled.
            hold[k] = stall_i[k] | (valid_q[k] & hold[k+1]);
`else
            hold[k] = stall_i[k] | hold[k+1];
`endif
        end
    end

    // Route each stage's upstream neighbour (or the producer) to its source.
    always_comb begin
        src_valid    = '0;
        src_valid[0] = in_valid_i;
        src_data[0]  = in_data_i;
        for (int k = 1; k < STAGES; k++) begin
            src_valid[k] = valid_q[k-1];
            src_data[k]  = data_q[k-1];
        end
    end

    // Per-stage next state: flush wins over hold, hold wins over load.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        for (int k = 0; k < STAGES; k++) begin
            if (flush_i[k]) begin
                // A flushed stage becomes a bubble even when held; upstream still
                // sees hold[k] so nothing above it is lost.
                valid_d[k] = 1'b0;
                data_d[k]  = '0;
            end else if (!hold[k]) begin
                // Data is copied even for bubbles so the taps stay deterministic.
                valid_d[k] = src_valid[k];
                data_d[k]  = src_data[k];
            end
        end
    end

    // Occupancy is the popcount of the next-state valids, so it is exact every cycle.
    always_comb begin
        occ_d = '0;
        for (int k = 0; k < STAGES; k++) begin
            occ_d = occ_d + CNTW'(valid_d[k]);
        end
    end

    // Stage registers and occupancy counter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            occ_q   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    // Output and tap wiring.
    always_comb begin
        tap_data_o = '0;
        for (int k = 0; k < STAGES; k++) begin
            tap_data_o[k*WIDTH +: WIDTH] = data_q[k];
        end
    end

    assign in_ready_o  = !hold[0];
    assign out_valid_o = valid_q[STAGES-1];
    assign out_data_o  = data_q[STAGES-1];
    assign tap_valid_o = valid_q;
    assign occupancy_o = occ_q;

`ifndef SYNTHESIS
    // The counter must track the valid vector and never exceed the stage count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            assert (32'(occ_d) == 32'($countones(valid_d)) && 32'(occ_d) <= STAGES);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_chain.sv
// Self-checking bench for pipe_chain: a 4-stage instance driven through scenario tasks
// with a scoreboard of accepted words, plus a 1-stage instance for the degenerate case.
module tb_pipe_chain;

    localparam int unsigned S  = 4;
    localparam int unsigned W  = 32;
    localparam int unsigned CW = $clog2(S + 1);

    logic            clk = 1'b0;
    logic            rst_i;
    logic            in_valid;
    logic [W-1:0]    in_data;
    logic            in_ready;
    logic [S-1:0]    stall;
    logic [S-1:0]    flush;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic            out_ready;
    logic [S*W-1:0]  tap_data;
    logic [S-1:0]    tap_valid;
    logic [CW-1:0]   occ;

    logic            s1_in_valid;
    logic [W-1:0]    s1_in_data;
    logic            s1_in_ready;
    logic [0:0]      s1_stall;
    logic [0:0]      s1_flush;
    logic            s1_out_valid;
    logic [W-1:0]    s1_out_data;
    logic            s1_out_ready;
    logic [W-1:0]    s1_tap_data;
    logic [0:0]      s1_tap_valid;
    logic [0:0]      s1_occ;

    int              n_tests = 0;
    int              n_fail  = 0;
    logic [W-1:0]    sb [$];
    logic            exp_collapse;

    always #5 clk = ~clk;

    pipe_chain #(.STAGES(S), .WIDTH(W)) u_dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .stall_i     (stall),
        .flush_i     (flush),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_ready_i (out_ready),
        .tap_data_o  (tap_data),
        .tap_valid_o (tap_valid),
        .occupancy_o (occ)
    );

    pipe_chain #(.STAGES(1), .WIDTH(W)) u_s1 (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .in_valid_i  (s1_in_valid),
        .in_data_i   (s1_in_data),
        .in_ready_o  (s1_in_ready),
        .stall_i     (s1_stall),
        .flush_i     (s1_flush),
        .out_valid_o (s1_out_valid),
        .out_data_o  (s1_out_data),
        .out_ready_i (s1_out_ready),
        .tap_data_o  (s1_tap_data),
        .tap_valid_o (s1_tap_valid),
        .occupancy_o (s1_occ)
    );

    // Scoreboard: push accepted words, pop and compare departing words, mid-cycle.
    always @(negedge clk) begin
        if (rst_i) begin
            if (in_valid && in_ready && !flush[0]) sb.push_back(in_data);
            if (out_valid && out_ready) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got %h, required no output", out_data);
                end else begin
                    logic [W-1:0] exp_w;
                    exp_w = sb.pop_front();
                    if (out_data !== exp_w) begin
                        n_fail++;
                        $display("FAIL sb_data: got %h, required %h", out_data, exp_w);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] tap(input int k);
        return tap_data[k*W +: W];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive idle and wait (bounded) for the chain to empty; reports whether it did.
    task automatic drain(output bit ok);
        int budget = 0;
        in_valid  = 1'b0;
        stall     = '0;
        flush     = '0;
        out_ready = 1'b1;
        while ((occ != 0 || out_valid) && budget < 20) begin
            tick();
            budget++;
        end
        ok = (occ == 0) && !out_valid;
    endtask

    task automatic test_reset();
        rst_i = 1'b0; in_valid = 1'b0; in_data = '0; stall = '0; flush = '0; out_ready = 1'b1;
        s1_in_valid = 1'b0; s1_in_data = '0; s1_stall = '0; s1_flush = '0; s1_out_ready = 1'b1;
        #12;
        n_tests++;
        if (tap_valid !== 4'b0000) begin
            n_fail++; $display("FAIL reset_tap_valid: got %b, required 0000", tap_valid);
        end
        n_tests++;
        if (occ !== 3'd0) begin
            n_fail++; $display("FAIL reset_occ: got %0d, required 0", occ);
        end
        n_tests++;
        if (tap_data !== '0) begin
            n_fail++; $display("FAIL reset_tap_data: got %h, required 0", tap_data);
        end
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hs: got ready=%b valid=%b, required 1 0", in_ready, out_valid);
        end
        n_tests++;
        if (s1_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_s1_valid: got %b, required 0", s1_out_valid);
        end
        @(negedge clk);
        #2;
        rst_i = 1'b1;
        tick();
    endtask

    task automatic test_latency();
        int   peak = 0;
        bit   ok;
        logic exp_v;
        logic [W-1:0] words [3];
        words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
        for (int c = 0; c < 10; c++) begin
            in_valid = (c < 3);
            in_data  = '0;
            if (c < 3) in_data = words[c];
            #1;
            exp_v = (c >= 4 && c <= 6);
            n_tests++;
            if (out_valid !== exp_v) begin
                n_fail++;
                $display("FAIL latency_valid_c%0d: got %b, required %b", c, out_valid, exp_v);
            end
            if (int'(occ) > peak) peak = int'(occ);
            tick();
        end
        n_tests++;
        if (peak != 3 || occ !== 3'd0) begin
            n_fail++; $display("FAIL latency_occ: got peak %0d end %0d, required 3 0", peak, occ);
        end
        drain(ok);
        n_tests++;
        if (!ok || sb.size() != 0) begin
            n_fail++; $display("FAIL latency_drain: got ok=%0d left=%0d, required 1 0", ok, sb.size());
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            in_data  = 32'hA0 + c;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_tests++;
            if (out_data !== 32'hA0 || in_ready !== 1'b0 || occ !== 3'd4) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got data=%h ready=%b occ=%0d, required a0 0 4",
                         i, out_data, in_ready, occ);
            end
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_tests++;
            if (out_valid !== (i < 4)) begin
                n_fail++;
                $display("FAIL bp_drain_%0d: got %b, required %b", i, out_valid, (i < 4));
            end
            tick();
        end
        drain(ok);
        n_tests++;
        if (!ok || sb.size() != 0) begin
            n_fail++; $display("FAIL bp_drain: got ok=%0d left=%0d, required 1 0", ok, sb.size());
        end
    endtask

    task automatic test_flush_stall();
        bit ok;
        logic [W-1:0] vals [4];
        vals[0] = 32'h0D; vals[1] = 32'h0C; vals[2] = 32'h0B; vals[3] = 32'h0A;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            in_data  = vals[c];
            tick();
        end
        // Chain: stage3=D, stage2=C, stage1=B, stage0=A.
        in_valid = 1'b0;
        stall    = 4'b0100;
        flush    = 4'b0100;
        #1;
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL fs_ready: got %b, required 0", in_ready);
        end
        tick();
        stall = '0;
        flush = '0;
        #1;
        n_tests++;
        if (tap_valid !== 4'b1011) begin
            n_fail++; $display("FAIL fs_valid: got %b, required 1011", tap_valid);
        end
        n_tests++;
        if (tap(3) !== 32'h0C || tap(2) !== 32'h0 || tap(1) !== 32'h0B || tap(0) !== 32'h0A) begin
            n_fail++;
            $display("FAIL fs_taps: got %h %h %h %h, required c 0 b a", tap(3), tap(2), tap(1), tap(0));
        end
        drain(ok);
        n_tests++;
        if (!ok || sb.size() != 0) begin
            n_fail++; $display("FAIL fs_drain: got ok=%0d left=%0d, required 1 0", ok, sb.size());
        end
        // Flush without stall: the word moving into stage 2 is killed.
        vals[0] = 32'hE1; vals[1] = 32'hF1; vals[2] = 32'h61; vals[3] = 32'h71;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            in_data  = vals[c];
            tick();
        end
        in_valid = 1'b0;
        flush    = 4'b0100;
        tick();
        flush = '0;
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i] == 32'h61) begin
                sb.delete(i);
                break;
            end
        end
        #1;
        n_tests++;
        if (tap_valid !== 4'b1010 || tap(3) !== 32'hF1 || tap(1) !== 32'h71) begin
            n_fail++;
            $display("FAIL kill_taps: got v=%b s3=%h s1=%h, required 1010 f1 71",
                     tap_valid, tap(3), tap(1));
        end
        drain(ok);
        n_tests++;
        if (!ok || sb.size() != 0) begin
            n_fail++; $display("FAIL kill_drain: got ok=%0d left=%0d, required 1 0", ok, sb.size());
        end
    endtask

    task automatic test_flush_all();
        bit ok;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_data  = 32'h90 + c;
            tick();
        end
        in_data = 32'h77;
        flush   = 4'b1111;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL flushall_ready: got %b, required 1", in_ready);
        end
        tick();
        flush    = '0;
        in_valid = 1'b0;
        sb.delete();
        #1;
        n_tests++;
        if (tap_valid !== 4'b0000 || occ !== 3'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flushall_state: got v=%b occ=%0d ov=%b, required 0000 0 0",
                     tap_valid, occ, out_valid);
        end
        drain(ok);
        n_tests++;
        if (!ok || sb.size() != 0) begin
            n_fail++; $display("FAIL flushall_drain: got ok=%0d left=%0d, required 1 0", ok, sb.size());
        end
    endtask

    task automatic test_midstream_reset();
        int seen = 0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_data  = 32'hC0 + c;
            tick();
        end
        in_valid = 1'b0;
        #2;
        rst_i = 1'b0;
        #1;
        n_tests++;
        if (tap_valid !== 4'b0000 || occ !== 3'd0 || tap_data !== '0) begin
            n_fail++;
            $display("FAIL arst_state: got v=%b occ=%0d data=%h, required 0000 0 0",
                     tap_valid, occ, tap_data);
        end
        sb.delete();
        tick();
        tick();
        @(negedge clk);
        #2;
        rst_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid || tap_valid != 0) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++; $display("FAIL arst_stale: got %0d stale cycles, required 0", seen);
        end
    endtask

    task automatic test_collapse();
        bit ok;
        for (int c = 0; c < 4; c++) begin
            in_valid = (c == 0 || c == 3);
            in_data  = (c == 0) ? 32'h5A : 32'h5B;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        n_tests++;
        if (tap_valid !== 4'b1001) begin
            n_fail++; $display("FAIL coll_start: got %b, required 1001", tap_valid);
        end
        n_tests++;
        if (in_ready !== exp_collapse) begin
            n_fail++; $display("FAIL coll_ready: got %b, required %b", in_ready, exp_collapse);
        end
        for (int p = 0; p < 2; p++) begin
            in_valid = 1'b1;
            in_data  = 32'h50 + p;
            tick();
        end
        in_valid = 1'b0;
        #1;
        n_tests++;
        if (tap_valid !== (exp_collapse ? 4'b1111 : 4'b1001) || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL coll_end: got v=%b ready=%b, required %b 0",
                     tap_valid, in_ready, (exp_collapse ? 4'b1111 : 4'b1001));
        end
        drain(ok);
        n_tests++;
        if (!ok || sb.size() != 0) begin
            n_fail++; $display("FAIL coll_drain: got ok=%0d left=%0d, required 1 0", ok, sb.size());
        end
    endtask

    task automatic test_stages1();
        s1_out_ready = 1'b1;
        s1_in_valid  = 1'b1;
        s1_in_data   = 32'hDEADBEEF;
        #1;
        n_tests++;
        if (s1_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL s1_ready_idle: got %b, required 1", s1_in_ready);
        end
        tick();
        s1_in_valid = 1'b0;
        #1;
        n_tests++;
        if (s1_out_valid !== 1'b1 || s1_out_data !== 32'hDEADBEEF || s1_occ !== 1'b1) begin
            n_fail++;
            $display("FAIL s1_out: got v=%b d=%h occ=%0d, required 1 deadbeef 1",
                     s1_out_valid, s1_out_data, s1_occ);
        end
        s1_out_ready = 1'b0;
        #1;
        n_tests++;
        if (s1_in_ready !== 1'b0) begin
            n_fail++; $display("FAIL s1_ready_full: got %b, required 0", s1_in_ready);
        end
        tick();
        n_tests++;
        if (s1_out_valid !== 1'b1 || s1_out_data !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL s1_hold: got v=%b d=%h, required 1 deadbeef", s1_out_valid, s1_out_data);
        end
        s1_out_ready = 1'b1;
        tick();
        s1_out_ready = 1'b0;
        #1;
        n_tests++;
        if (s1_out_valid !== 1'b0 || s1_in_ready !== exp_collapse) begin
            n_fail++;
            $display("FAIL s1_empty: got v=%b ready=%b, required 0 %b",
                     s1_out_valid, s1_in_ready, exp_collapse);
        end
        s1_out_ready = 1'b1;
        tick();
    endtask

    initial begin
`ifdef PIPE_CHAIN_BUBBLE_COLLAPSE_EN
        exp_collapse = 1'b1;
`else
        exp_collapse = 1'b0;
`endif
        test_reset();
        test_latency();
        test_backpressure();
        test_flush_stall();
        test_flush_all();
        test_midstream_reset();
        test_collapse();
        test_stages1();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
